// File: rtl/time_set_ctrl_pkg.sv
// Shared state/mode codes and small decode helpers for the clock time-set controller.
// The display mux imports the same codes to pick which digit blinks.
package time_set_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_RUN    = 3'd0,
    ST_SET_ML = 3'd1,
    ST_SET_MH = 3'd2,
    ST_SET_HL = 3'd3,
    ST_SET_HH = 3'd4
  } state_e;

  function automatic state_e next_mode(input state_e s);
    case (s)
      ST_RUN:    return ST_SET_ML;
      ST_SET_ML: return ST_SET_MH;
      ST_SET_MH: return ST_SET_HL;
      ST_SET_HL: return ST_SET_HH;
      default:   return ST_RUN;
    endcase
  endfunction

  // Strobe vector order: {min_set_l, min_set_h, hr_set_l, hr_set_h}
  function automatic logic [3:0] set_strobe(input state_e s);
    case (s)
      ST_SET_ML: return 4'b1000;
      ST_SET_MH: return 4'b0100;
      ST_SET_HL: return 4'b0010;
      ST_SET_HH: return 4'b0001;
      default:   return 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/time_set_ctrl_btn_debounce.sv
// Front-panel button conditioner: 2-flop synchronizer, stability counter and
// a one-cycle press event on each 0->1 edge of the debounced level.
module time_set_ctrl_btn_debounce #(
  parameter int DEB_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic level,
  output logic press
);

  localparam int CW = $clog2(DEB_CYCLES + 1);

  logic          sync1_q, sync2_q;
  logic          deb_q, deb_d;
  logic          deb_prev_q;
  logic [CW-1:0] cnt_q, cnt_d;

  // Counter runs only while the synchronized level disagrees with the
  // debounced one; any agreement restarts it, so it never passes DEB_CYCLES.
  always_comb begin
    deb_d = deb_q;
    cnt_d = '0;
    if (sync2_q != deb_q) begin
      if (cnt_q == CW'(DEB_CYCLES)) deb_d = sync2_q;
      else                          cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      deb_q      <= 1'b0;
      deb_prev_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      sync1_q    <= btn_raw;
      sync2_q    <= sync1_q;
      deb_q      <= deb_d;
      deb_prev_q <= deb_q;
      cnt_q      <= cnt_d;
    end
  end

  assign level = deb_q;
  assign press = deb_q & ~deb_prev_q;

endmodule

// File: rtl/time_set_ctrl.sv
// RUN/SET mode controller: debounced buttons, set strobes with auto-repeat,
// inactivity timeout back to RUN, and the edit-digit blink phase.
//   state     | meaning
//   ST_RUN    | clock running, buttons only advance mode
//   ST_SET_ML | editing minute low digit, seconds frozen
//   ST_SET_MH | editing minute high digit
//   ST_SET_HL | editing hour low digit
//   ST_SET_HH | editing hour high digit
module time_set_ctrl
  import time_set_ctrl_pkg::*;
#(
  parameter int DEB_CYCLES    = 500000,
  parameter int REPEAT_START  = 25000000,
  parameter int REPEAT_RATE   = 5000000,
  parameter int TIMEOUT_TICKS = 30
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       tick_1hz,
  output logic       run_en,
  output logic       sec_clr,
  output logic       min_set_l,
  output logic       min_set_h,
  output logic       hr_set_l,
  output logic       hr_set_h,
  output logic [2:0] mode,
  output logic       blink
);

  localparam int RW = $clog2(REPEAT_START + 1);
  localparam int TW = $clog2(TIMEOUT_TICKS + 1);
  // Reload so the counter climbs back to REPEAT_START after REPEAT_RATE cycles
  localparam int RPT_RELOAD = (REPEAT_RATE >= REPEAT_START) ? 1
                                                            : REPEAT_START - REPEAT_RATE + 1;

  logic mode_lvl, mode_press, inc_lvl, inc_ev;
  logic mode_ev;

  time_set_ctrl_btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_mode (
    .clk    (clk),
    .rst_n  (rst_n),
    .btn_raw(btn_mode),
    .level  (mode_lvl),
    .press  (mode_press)
  );

  time_set_ctrl_btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_inc (
    .clk    (clk),
    .rst_n  (rst_n),
    .btn_raw(btn_inc),
    .level  (inc_lvl),
    .press  (inc_ev)
  );

  assign mode_ev = mode_press & mode_lvl;

  state_e        state_q, state_d;
  logic          sec_clr_q, sec_clr_d;
  logic [3:0]    set_q, set_d;
  logic          run_en_q, run_en_d;
  logic          blink_q, blink_d;
  logic [RW-1:0] rpt_q, rpt_d;
  logic [TW-1:0] to_q, to_d;
  logic          in_set, timeout_hit;

  always_comb begin
    state_d     = state_q;
    sec_clr_d   = 1'b0;
    set_d       = 4'b0000;
    rpt_d       = rpt_q;
    to_d        = to_q;
    in_set      = (state_q != ST_RUN);
    timeout_hit = in_set && tick_1hz && (to_q == TW'(TIMEOUT_TICKS - 1));

    if (mode_ev) begin
      state_d   = next_mode(state_q);
      sec_clr_d = (state_q == ST_RUN);
      rpt_d     = '0;
      to_d      = '0;
    end else if (inc_ev && in_set) begin
      set_d = set_strobe(state_q);
      rpt_d = RW'(1);
      to_d  = '0;
    end else if (in_set) begin
      if (timeout_hit) begin
        state_d = ST_RUN;
        rpt_d   = '0;
        to_d    = '0;
      end else begin
        if (tick_1hz) to_d = to_q + 1'b1;
        // rpt_q == 0 means no repeat armed for the current hold
        if (!inc_lvl) begin
          rpt_d = '0;
        end else if (rpt_q == RW'(REPEAT_START)) begin
          set_d = set_strobe(state_q);
          rpt_d = RW'(RPT_RELOAD);
        end else if (rpt_q != '0) begin
          rpt_d = rpt_q + 1'b1;
        end
      end
    end

    run_en_d = (state_d == ST_RUN);
    blink_d  = (state_d == ST_RUN) ? 1'b0 : (blink_q ^ (tick_1hz & in_set));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_RUN;
      sec_clr_q <= 1'b0;
      set_q     <= 4'b0000;
      run_en_q  <= 1'b1;
      blink_q   <= 1'b0;
      rpt_q     <= '0;
      to_q      <= '0;
    end else begin
      state_q   <= state_d;
      sec_clr_q <= sec_clr_d;
      set_q     <= set_d;
      run_en_q  <= run_en_d;
      blink_q   <= blink_d;
      rpt_q     <= rpt_d;
      to_q      <= to_d;
    end
  end

  assign mode      = state_q;
  assign run_en    = run_en_q;
  assign sec_clr   = sec_clr_q;
  assign min_set_l = set_q[3];
  assign min_set_h = set_q[2];
  assign hr_set_l  = set_q[1];
  assign hr_set_h  = set_q[0];
  assign blink     = blink_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Bench for time_set_ctrl: directed scenarios plus a randomized run checked
// cycle by cycle against a behavioural model of the mode/time-set rules.
module tb_time_set_ctrl;

  localparam int DEB = 4;
  localparam int RS  = 20;
  localparam int RR  = 5;
  localparam int TO  = 3;
  localparam logic [9:0] RESET_VEC = 10'b000_1_0_0000_0;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic btn_mode = 1'b0;
  logic btn_inc = 1'b0;
  logic tick_1hz = 1'b0;
  logic run_en, sec_clr, min_set_l, min_set_h, hr_set_l, hr_set_h, blink;
  logic [2:0] mode;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  time_set_ctrl #(
    .DEB_CYCLES(DEB), .REPEAT_START(RS), .REPEAT_RATE(RR), .TIMEOUT_TICKS(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .btn_mode(btn_mode), .btn_inc(btn_inc),
    .tick_1hz(tick_1hz), .run_en(run_en), .sec_clr(sec_clr),
    .min_set_l(min_set_l), .min_set_h(min_set_h), .hr_set_l(hr_set_l),
    .hr_set_h(hr_set_h), .mode(mode), .blink(blink)
  );

  function automatic logic [9:0] dut_vec();
    return {mode, run_en, sec_clr, min_set_l, min_set_h, hr_set_l, hr_set_h, blink};
  endfunction

  function automatic int n_strobes();
    return int'(min_set_l) + int'(min_set_h) + int'(hr_set_l) + int'(hr_set_h);
  endfunction

  // ---------------- behavioural reference model ----------------
  bit   hq_m[$];
  bit   hq_i[$];
  int   m_n, m_st, m_to, m_rnext;
  bit   m_ract, m_blink, m_deb_m, m_deb_i, m_ev_m, m_ev_i;
  logic [9:0] exp_vec = RESET_VEC;

  // Debounced level flips once the DEB+1 raw samples ending two edges ago
  // (synchronizer delay) all show the new value; samples before reset read 0.
  function automatic bit raw_stable(input bit which_inc, input bit v);
    int idx;
    bit s;
    for (int k = 0; k <= DEB; k++) begin
      idx = (which_inc ? hq_i.size() : hq_m.size()) - 3 - k;
      if (idx < 0) s = 1'b0;
      else         s = which_inc ? hq_i[idx] : hq_m[idx];
      if (s != v) return 1'b0;
    end
    return 1'b1;
  endfunction

  always @(posedge clk or negedge rst_n) begin : mdl
    int old_st, sst;
    bit sc, nd;
    if (!rst_n) begin
      hq_m.delete(); hq_i.delete();
      m_n = 0; m_st = 0; m_to = 0; m_rnext = 0;
      m_ract = 0; m_blink = 0; m_deb_m = 0; m_deb_i = 0; m_ev_m = 0; m_ev_i = 0;
      exp_vec = RESET_VEC;
    end else begin
      old_st = m_st; sst = 0; sc = 0;
      if (m_ev_m) begin
        m_st = (m_st + 1) % 5; sc = (old_st == 0); m_to = 0; m_ract = 0;
      end else if (m_ev_i && m_st != 0) begin
        sst = m_st; m_to = 0; m_ract = 1; m_rnext = m_n + RS;
      end else if (m_st != 0) begin
        if (tick_1hz) m_to++;
        if (m_to >= TO) begin
          m_st = 0; m_to = 0; m_ract = 0;
        end else if (!m_deb_i) begin
          m_ract = 0;
        end else if (m_ract && m_n == m_rnext) begin
          sst = m_st; m_rnext = m_rnext + RR;
        end
      end
      if (m_st == 0) m_blink = 0;
      else if (tick_1hz && old_st != 0) m_blink = ~m_blink;

      hq_m.push_back(btn_mode); hq_i.push_back(btn_inc);
      if (hq_m.size() > 16) void'(hq_m.pop_front());
      if (hq_i.size() > 16) void'(hq_i.pop_front());
      nd = raw_stable(1'b0, ~m_deb_m) ? ~m_deb_m : m_deb_m;
      m_ev_m = nd & ~m_deb_m; m_deb_m = nd;
      nd = raw_stable(1'b1, ~m_deb_i) ? ~m_deb_i : m_deb_i;
      m_ev_i = nd & ~m_deb_i; m_deb_i = nd;
      m_n++;
      exp_vec = {3'(m_st), m_st == 0, sc, sst == 1, sst == 2, sst == 3, sst == 4, m_blink};
    end
  end

  // ---------------- stimulus helpers (no checking) ----------------
  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic hold_btn(input bit m, input bit i, input int n, input int rel);
    btn_mode = m; btn_inc = i;
    cyc(n);
    btn_mode = 0; btn_inc = 0;
    cyc(rel);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 0; btn_mode = 0; btn_inc = 0; tick_1hz = 0;
    cyc(2);
    checks++;
    if (dut_vec() !== RESET_VEC) begin
      failures++; $display("FAIL reset_held got=%b want=%b", dut_vec(), RESET_VEC);
    end
    rst_n = 1;
    for (int c = 0; c < 50; c++) begin
      cyc(1);
      checks++;
      if (dut_vec() !== RESET_VEC) begin
        failures++; $display("FAIL reset_idle cyc=%0d got=%b want=%b", c, dut_vec(), RESET_VEC);
      end
    end
  endtask

  task automatic test_glitch_and_mode();
    btn_mode = 1; cyc(3); btn_mode = 0; cyc(20);
    checks++;
    if (dut_vec() !== RESET_VEC) begin
      failures++; $display("FAIL mode_glitch got=%b want=%b", dut_vec(), RESET_VEC);
    end
    btn_mode = 1;
    for (int k = 0; k < 10; k++) begin
      cyc(1);
      if (k == 6) begin
        checks++;
        if (mode !== 3'd0) begin
          failures++; $display("FAIL mode_early cyc=%0d got=%0d want=0", k, mode);
        end
      end
      if (k == 7) begin
        checks++;
        if ({mode, sec_clr, run_en} !== {3'd1, 1'b1, 1'b0}) begin
          failures++;
          $display("FAIL mode_enter cyc=%0d got mode=%0d sec_clr=%b run_en=%b want 1/1/0", k, mode, sec_clr, run_en);
        end
      end
      if (k == 8) begin
        checks++;
        if ({mode, sec_clr, run_en} !== {3'd1, 1'b0, 1'b0}) begin
          failures++;
          $display("FAIL sec_clr_width got mode=%0d sec_clr=%b run_en=%b want 1/0/0", mode, sec_clr, run_en);
        end
      end
    end
    btn_mode = 0; cyc(15);
  endtask

  task automatic test_inc_repeat();
    int np, nother, c, first;
    int pulses[$];
    hold_btn(1, 0, 10, 15);
    checks++;
    if (mode !== 3'd2) begin
      failures++; $display("FAIL enter_mh got=%0d want=2", mode);
    end
    np = 0; nother = 0;
    btn_inc = 1;
    for (int k = 0; k < 40; k++) begin
      if (k == 10) btn_inc = 0;
      cyc(1);
      np += int'(min_set_h);
      nother += int'(min_set_l) + int'(hr_set_l) + int'(hr_set_h);
    end
    checks++;
    if (np != 1 || nother != 0) begin
      failures++; $display("FAIL inc_single got min_h=%0d other=%0d want 1/0", np, nother);
    end
    btn_inc = 1; c = 0;
    for (int k = 0; k < 70; k++) begin
      if (k == 40) btn_inc = 0;
      cyc(1);
      if (min_set_h) pulses.push_back(c);
      nother += int'(min_set_l) + int'(hr_set_l) + int'(hr_set_h);
      c++;
    end
    checks++;
    if (pulses.size() != 5 || nother != 0) begin
      failures++; $display("FAIL repeat_count got=%0d other=%0d want 5/0", pulses.size(), nother);
    end else begin
      first = pulses[0];
      for (int i = 1; i < 5; i++) begin
        checks++;
        if (pulses[i] - first != RS + (i - 1) * RR) begin
          failures++;
          $display("FAIL repeat_spacing idx=%0d got=%0d want=%0d", i, pulses[i] - first, RS + (i - 1) * RR);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int ns;
    ns = 0;
    btn_mode = 1; btn_inc = 1;
    for (int k = 0; k < 25; k++) begin
      if (k == 10) begin btn_mode = 0; btn_inc = 0; end
      cyc(1);
      ns += n_strobes();
    end
    checks++;
    if (mode !== 3'd3 || ns != 0) begin
      failures++; $display("FAIL simul_events got mode=%0d strobes=%0d want 3/0", mode, ns);
    end
  endtask

  task automatic test_timeout();
    tick_1hz = 1; cyc(1); tick_1hz = 0;
    checks++;
    if ({mode, blink} !== {3'd3, 1'b1}) begin
      failures++; $display("FAIL tick1 got mode=%0d blink=%b want 3/1", mode, blink);
    end
    cyc(4);
    tick_1hz = 1; cyc(1); tick_1hz = 0;
    checks++;
    if ({mode, blink} !== {3'd3, 1'b0}) begin
      failures++; $display("FAIL tick2 got mode=%0d blink=%b want 3/0", mode, blink);
    end
    cyc(4);
    tick_1hz = 1; cyc(1); tick_1hz = 0;
    checks++;
    if (dut_vec() !== RESET_VEC) begin
      failures++; $display("FAIL timeout_run got=%b want=%b", dut_vec(), RESET_VEC);
    end
    cyc(4);
    for (int i = 0; i < 3; i++) hold_btn(1, 0, 10, 15);
    checks++;
    if (mode !== 3'd3) begin
      failures++; $display("FAIL reenter_hl got=%0d want=3", mode);
    end
    for (int i = 0; i < 2; i++) begin tick_1hz = 1; cyc(1); tick_1hz = 0; cyc(4); end
    hold_btn(0, 1, 10, 15);
    for (int i = 0; i < 2; i++) begin tick_1hz = 1; cyc(1); tick_1hz = 0; cyc(4); end
    checks++;
    if (mode !== 3'd3) begin
      failures++; $display("FAIL timeout_cleared got=%0d want=3", mode);
    end
    tick_1hz = 1; cyc(1); tick_1hz = 0;
    checks++;
    if (mode !== 3'd0 || run_en !== 1'b1) begin
      failures++; $display("FAIL timeout_after_press got mode=%0d run_en=%b want 0/1", mode, run_en);
    end
    cyc(4);
  endtask

  task automatic test_reset_mid();
    int ns;
    for (int i = 0; i < 4; i++) hold_btn(1, 0, 10, 15);
    checks++;
    if (mode !== 3'd4) begin
      failures++; $display("FAIL enter_hh got=%0d want=4", mode);
    end
    btn_inc = 1; cyc(30);
    #2 rst_n = 0;
    #1;
    checks++;
    if (dut_vec() !== RESET_VEC) begin
      failures++; $display("FAIL async_reset got=%b want=%b", dut_vec(), RESET_VEC);
    end
    cyc(3);
    #3 rst_n = 1;
    ns = 0;
    for (int k = 0; k < 40; k++) begin cyc(1); ns += n_strobes(); end
    checks++;
    if (mode !== 3'd0 || ns != 0) begin
      failures++; $display("FAIL post_reset_run got mode=%0d strobes=%0d want 0/0", mode, ns);
    end
    ns = 0;
    btn_mode = 1;
    for (int k = 0; k < 50; k++) begin
      if (k == 10) btn_mode = 0;
      cyc(1); ns += n_strobes();
    end
    checks++;
    if (mode !== 3'd1 || ns != 0) begin
      failures++; $display("FAIL held_inc_no_strobe got mode=%0d strobes=%0d want 1/0", mode, ns);
    end
    btn_inc = 0; cyc(15);
    ns = 0;
    btn_inc = 1;
    for (int k = 0; k < 25; k++) begin
      if (k == 10) btn_inc = 0;
      cyc(1); ns += int'(min_set_l);
    end
    checks++;
    if (ns != 1) begin
      failures++; $display("FAIL fresh_press got min_l=%0d want 1", ns);
    end
  endtask

  task automatic test_random();
    int hm, hi;
    bit prev_tick;
    rst_n = 0; btn_mode = 0; btn_inc = 0; tick_1hz = 0;
    cyc(2);
    rst_n = 1;
    hm = 0; hi = 0; prev_tick = 0;
    for (int c = 0; c < 4000; c++) begin
      if (hm == 0) begin btn_mode = $urandom_range(0, 3) == 0; hm = $urandom_range(1, 40); end
      if (hi == 0) begin btn_inc = $urandom_range(0, 1); hi = $urandom_range(1, 60); end
      hm--; hi--;
      tick_1hz = !prev_tick && ($urandom_range(0, 11) == 0);
      prev_tick = tick_1hz;
      cyc(1);
      checks++;
      if (dut_vec() !== exp_vec) begin
        failures++; $display("FAIL random_model cyc=%0d got=%b want=%b", c, dut_vec(), exp_vec);
      end
      checks++;
      if (n_strobes() > 1) begin
        failures++; $display("FAIL strobe_onehot cyc=%0d got=%0d want<=1", c, n_strobes());
      end
    end
    btn_mode = 0; btn_inc = 0; tick_1hz = 0;
  endtask

  initial begin
    test_reset();
    test_glitch_and_mode();
    test_inc_repeat();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
